// File: rtl/channel_estimator_mlane.sv
// rtl/channel_estimator_mlane.sv - multi-lane saturating LMS channel estimator with command port
// Optional tap leakage is compiled in with `define CHAN_EST_LEAK_EN.
module channel_estimator_mlane #(
   parameter int est_depth      = 30,
   parameter int est_bitwidth   = 8,
   parameter int adapt_bitwidth = 16,
   parameter int err_bitwidth   = 9,
   parameter int num_lanes      = 2,
   parameter int leak_shift     = 12
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [err_bitwidth*est_depth-1:0]      error,
   input  logic [1:0]                             sym,
   input  logic                                   upd_valid,
   input  logic [$clog2(adapt_bitwidth)-1:0]      gain,
   input  logic                                   cmd_valid,
   output logic                                   cmd_ready,
   input  logic [1:0]                             cmd_op,
   input  logic [$clog2(est_depth)-1:0]           cmd_addr,
   input  logic [est_bitwidth-1:0]                cmd_val,
   output logic                                   rd_valid,
   output logic [est_bitwidth+adapt_bitwidth-1:0] rd_data,
   output logic                                   sweep_done,
   output logic                                   frozen,
   output logic [est_bitwidth*est_depth-1:0]      est_chan
);

   localparam int W   = est_bitwidth + adapt_bitwidth;
   localparam int AW  = err_bitwidth + adapt_bitwidth + 2;
   // Sum width leaves headroom for the largest adj so the clamp sees the true sign.
   localparam int SW  = ((AW > W) ? AW : W) + 2;
   localparam int GW  = $clog2(adapt_bitwidth);
   localparam int CAW = $clog2(est_depth);

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_READ   = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;
   localparam logic [1:0] OP_FREEZE = 2'b11;

   typedef enum logic [1:0] {S_RUN, S_FROZEN, S_CLEAR} state_t;

   if (num_lanes < 1 || num_lanes > est_depth) begin : g_bad_lanes
      $error("num_lanes must be within 1..est_depth");
   end
   if (leak_shift < 0 || leak_shift >= W) begin : g_bad_leak
      $error("leak_shift must be within 0..W-1");
   end

   state_t                  state, state_nxt, ret_state;
   logic signed [W-1:0]     int_chan [est_depth];
   logic signed [W-1:0]     tap_next [est_depth];
   logic signed [err_bitwidth-1:0] err_arr [est_depth];
   logic [CAW-1:0]          gp;
   logic [CAW-1:0]          cp;
   logic                    cmd_acc;
   logic                    addr_ok;
   logic                    upd_en;
   logic                    grp_last;
   logic                    clear_last;

   // Unpack the flat error bus and export the integer part of each tap.
   for (genvar i = 0; i < est_depth; i++) begin : g_lane_io
      assign err_arr[i] = error[i*err_bitwidth +: err_bitwidth];
      assign est_chan[i*est_bitwidth +: est_bitwidth] = int_chan[i][W-1:adapt_bitwidth];
   end

   assign cmd_acc    = cmd_valid & cmd_ready;
   assign addr_ok    = int'(cmd_addr) < est_depth;
   assign upd_en     = (state == S_RUN) && upd_valid;
   assign grp_last   = int'(gp) + num_lanes >= est_depth;
   assign clear_last = int'(cp) + num_lanes >= est_depth;

   // One tap update: cur + sym weight * (err <<< gain), optionally leaked, clamped to W bits.
   function automatic logic signed [W-1:0] upd_tap(
      input logic signed [W-1:0]            cur,
      input logic signed [err_bitwidth-1:0] e,
      input logic [1:0]                     s,
      input logic [GW-1:0]                  g
   );
      logic signed [AW-1:0] es;
      logic signed [AW-1:0] adj;
      logic signed [SW-1:0] sum;
`ifdef CHAN_EST_LEAK_EN
      logic signed [W-1:0]  lk;
`endif
      es = {{(AW-err_bitwidth){e[err_bitwidth-1]}}, e};
      es = es <<< g;
      case (s)
         2'b00:   adj = es;
         2'b01:   adj = es + (es <<< 1);
         2'b10:   adj = -es;
         default: adj = -(es + (es <<< 1));
      endcase
      sum = {{(SW-W){cur[W-1]}}, cur} + {{(SW-AW){adj[AW-1]}}, adj};
`ifdef CHAN_EST_LEAK_EN
      lk  = cur >>> leak_shift;
      sum = sum - {{(SW-W){lk[W-1]}}, lk};
`endif
      if (sum[SW-1:W-1] == {(SW-W+1){sum[SW-1]}}) begin
         return sum[W-1:0];
      end else if (sum[SW-1]) begin
         return {1'b1, {(W-1){1'b0}}};
      end else begin
         return {1'b0, {(W-1){1'b1}}};
      end
   endfunction

   // Next tap values: group update, then clear sweep, then LOAD (LOAD wins on overlap).
   always_comb begin
      for (int i = 0; i < est_depth; i++) begin
         tap_next[i] = int_chan[i];
      end
      if (upd_en) begin
         for (int l = 0; l < num_lanes; l++) begin
            if (int'(gp) + l < est_depth) begin
               tap_next[CAW'(int'(gp) + l)] = upd_tap(int_chan[CAW'(int'(gp) + l)],
                                                      err_arr[CAW'(int'(gp) + l)], sym, gain);
            end
         end
      end
      if (state == S_CLEAR) begin
         for (int l = 0; l < num_lanes; l++) begin
            if (int'(cp) + l < est_depth) begin
               tap_next[CAW'(int'(cp) + l)] = '0;
            end
         end
      end
      if (cmd_acc && cmd_op == OP_LOAD && addr_ok) begin
         tap_next[cmd_addr] = {cmd_val, {adapt_bitwidth{1'b0}}};
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: commands move between RUN/FROZEN/CLEAR; CLEAR returns to the saved state.
   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN, S_FROZEN: begin
            if (cmd_acc && cmd_op == OP_CLEAR) begin
               state_nxt = S_CLEAR;
            end else if (cmd_acc && cmd_op == OP_FREEZE) begin
               state_nxt = cmd_val[0] ? S_FROZEN : S_RUN;
            end
         end
         S_CLEAR: begin
            if (clear_last) begin
               state_nxt = ret_state;
            end
         end
         default: state_nxt = S_RUN;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      cmd_ready = (state != S_CLEAR);
      frozen    = (state == S_FROZEN);
   end

   // Tap registers, group/clear pointers, read-back and sweep pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < est_depth; i++) begin
            int_chan[i] <= '0;
         end
         gp         <= '0;
         cp         <= '0;
         ret_state  <= S_RUN;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         sweep_done <= 1'b0;
      end else begin
         for (int i = 0; i < est_depth; i++) begin
            int_chan[i] <= tap_next[i];
         end
         rd_valid   <= 1'b0;
         sweep_done <= 1'b0;
         if (upd_en) begin
            if (grp_last) begin
               gp         <= '0;
               sweep_done <= 1'b1;
            end else begin
               gp <= gp + CAW'(num_lanes);
            end
         end
         if (state == S_CLEAR) begin
            if (clear_last) begin
               cp <= '0;
               gp <= '0;
            end else begin
               cp <= cp + CAW'(num_lanes);
            end
         end
         if (cmd_acc && cmd_op == OP_CLEAR) begin
            cp        <= '0;
            ret_state <= (state == S_FROZEN) ? S_FROZEN : S_RUN;
         end
         if (cmd_acc && cmd_op == OP_READ) begin
            rd_valid <= 1'b1;
            rd_data  <= addr_ok ? int_chan[cmd_addr] : '0;
         end
      end
   end

endmodule

// File: tb/tb_channel_estimator_mlane.sv
// tb/tb_channel_estimator_mlane.sv - directed self-checking bench for channel_estimator_mlane
module tb_channel_estimator_mlane;

   localparam int D  = 30;
   localparam int EB = 8;
   localparam int AB = 16;
   localparam int EW = 9;
   localparam int NL = 2;
   localparam int W  = EB + AB;

   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_READ   = 2'b01;
   localparam logic [1:0] OP_CLEAR  = 2'b10;
   localparam logic [1:0] OP_FREEZE = 2'b11;

   logic          clk = 1'b0;
   logic          rst;
   logic [EW*D-1:0] error;
   logic [1:0]    sym;
   logic          upd_valid;
   logic [3:0]    gain;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [4:0]    cmd_addr;
   logic [EB-1:0] cmd_val;
   logic          rd_valid;
   logic [W-1:0]  rd_data;
   logic          sweep_done;
   logic          frozen;
   logic [EB*D-1:0] est_chan;

   int n_cmp = 0;
   int n_err = 0;
   int sweeps;
   int sweep_at;
   int low_cnt;

   channel_estimator_mlane #(
      .est_depth(D), .est_bitwidth(EB), .adapt_bitwidth(AB),
      .err_bitwidth(EW), .num_lanes(NL), .leak_shift(2)
   ) dut (
      .clk(clk), .rst(rst), .error(error), .sym(sym), .upd_valid(upd_valid),
      .gain(gain), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_val(cmd_val), .rd_valid(rd_valid), .rd_data(rd_data),
      .sweep_done(sweep_done), .frozen(frozen), .est_chan(est_chan)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic longint est(input int i);
      logic signed [EB-1:0] v;
      v = est_chan[i*EB +: EB];
      return longint'(v);
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic signed [EB-1:0] v);
      logic [EB*D-1:0] expv;
      for (int i = 0; i < D; i++) expv[i*EB +: EB] = v;
      n_cmp++;
      assert (est_chan === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, est_chan, expv);
      end
   endtask

   task automatic set_err(input logic signed [EW-1:0] v);
      for (int i = 0; i < D; i++) error[i*EW +: EW] = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [1:0] op, input logic [4:0] addr, input logic [EB-1:0] val);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_val   = val;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; upd_valid = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
      cmd_val = '0; sym = '0; gain = '0; set_err(0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_sweep_done", sweep_done, 0);
      chk("rst_frozen", frozen, 0);
      chk_all("rst_est_chan", 0);
      rst = 1'b0;
      step();

      // One full sweep with +4 error, gain 15, symbol +1.
      gain = 4'd15; set_err(4); sym = 2'b00; upd_valid = 1'b1;
      sweeps = 0; sweep_at = 0;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (sweep_done) begin sweeps++; sweep_at = c; end
         if (c == 1) begin
            chk("grp0_tap0", est(0), 2);
            chk("grp0_tap1", est(1), 2);
            chk("grp0_tap2", est(2), 0);
         end
      end
      upd_valid = 1'b0;
      step();
      if (sweep_done) sweeps++;
      chk("sweep_count", sweeps, 1);
      chk("sweep_cycle", sweep_at, 15);
      chk_all("sweep_plus1", 2);

      // Back-to-back READs, the second out of range.
      cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 5'd5;
      step();
      chk("rd5_valid", rd_valid, 1);
      chk("rd5_data", rd_data, 131072);
      cmd_addr = 5'd31;
      step();
      cmd_valid = 1'b0;
      chk("rd31_valid", rd_valid, 1);
      chk("rd31_data", rd_data, 0);
      step();
      chk("rd_pulse_end", rd_valid, 0);

      // Symbol -3 sweep from reset.
      do_reset();
      gain = 4'd15; set_err(4); sym = 2'b11; upd_valid = 1'b1;
      repeat (15) step();
      upd_valid = 1'b0;
      chk_all("sweep_minus3", -6);

      // Saturation at both rails, LOAD-wins and read-before-update.
      do_reset();
      cmd(OP_LOAD, 5'd0, 8'd127);
      chk("load_est0", est(0), 127);
      cmd(OP_READ, 5'd0, 8'd0);
      chk("load_rd0", $signed(rd_data), 8323072);
      set_err(255); gain = 4'd15; sym = 2'b01; upd_valid = 1'b1;
      step();
      upd_valid = 1'b0;
      cmd(OP_READ, 5'd0, 8'd0);
      chk("sat_pos_rd0", $signed(rd_data), 8388607);
      chk("sat_pos_est0", est(0), 127);
      chk("sat_pos_est1", est(1), 127);
      sym = 2'b11; upd_valid = 1'b1;
      step();
      upd_valid = 1'b0;
      chk("sat_neg_est2", est(2), -128);
      cmd(OP_READ, 5'd3, 8'd0);
      chk("sat_neg_rd3", $signed(rd_data), -8388608);
      upd_valid = 1'b1; cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_addr = 5'd4; cmd_val = 8'hFB;
      step();
      upd_valid = 1'b0; cmd_valid = 1'b0;
      chk("load_wins_est4", est(4), -5);
      chk("load_wins_est5", est(5), -128);
      sym = 2'b01; upd_valid = 1'b1; cmd_valid = 1'b1; cmd_op = OP_READ; cmd_addr = 5'd6;
      step();
      upd_valid = 1'b0; cmd_valid = 1'b0;
      chk("rd_old_valid", rd_valid, 1);
      chk("rd_old_data", rd_data, 0);
      chk("rd_old_est6", est(6), 127);

      // FREEZE holds taps and gp; unfreeze resumes at the held group.
      do_reset();
      set_err(4); gain = 4'd15; sym = 2'b00; upd_valid = 1'b1;
      step();
      upd_valid = 1'b0;
      cmd(OP_FREEZE, 5'd0, 8'd1);
      chk("frz_frozen", frozen, 1);
      chk("frz_ready", cmd_ready, 1);
      sweeps = 0; upd_valid = 1'b1;
      repeat (20) begin
         step();
         if (sweep_done) sweeps++;
      end
      upd_valid = 1'b0;
      chk("frz_est0", est(0), 2);
      chk("frz_est2", est(2), 0);
      chk("frz_no_sweep", sweeps, 0);
      cmd(OP_FREEZE, 5'd0, 8'd0);
      chk("unfrz_frozen", frozen, 0);
      upd_valid = 1'b1;
      step();
      upd_valid = 1'b0;
      chk("resume_est2", est(2), 2);
      chk("resume_est3", est(3), 2);
      chk("resume_est4", est(4), 0);

      // CLEAR: ready low for 15 cycles; a LOAD waits until ready returns.
      cmd(OP_CLEAR, 5'd0, 8'd0);
      cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_addr = 5'd0; cmd_val = 8'd50;
      low_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (cmd_ready) break;
         low_cnt++;
         step();
      end
      chk("clr_low_cycles", low_cnt, 15);
      chk_all("clr_zero", 0);
      chk("clr_back_run", frozen, 0);
      step();
      cmd_valid = 1'b0;
      chk("clr_load_est0", est(0), 50);
      upd_valid = 1'b1;
      step();
      upd_valid = 1'b0;
`ifdef CHAN_EST_LEAK_EN
      chk("clr_gp0_est0", est(0), 39);
`else
      chk("clr_gp0_est0", est(0), 52);
`endif
      chk("clr_gp0_est1", est(1), 2);
      chk("clr_gp0_est2", est(2), 0);

      // Reset mid-CLEAR.
      cmd(OP_CLEAR, 5'd0, 8'd0);
      step();
      chk("midclr_ready", cmd_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("midclr_rst_ready", cmd_ready, 1);
      rst = 1'b0;
      step();

      // Reset mid-sweep with a READ pulse outstanding.
      set_err(4); gain = 4'd15; sym = 2'b00; upd_valid = 1'b1;
      repeat (3) step();
      cmd(OP_READ, 5'd0, 8'd0);
      chk("midsw_rd_valid", rd_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("midsw_rst_rd_valid", rd_valid, 0);
      chk("midsw_rst_rd_data", rd_data, 0);
      chk("midsw_rst_sweep", sweep_done, 0);
      chk_all("midsw_rst_est", 0);
      upd_valid = 1'b0;
      rst = 1'b0;
      step();
      upd_valid = 1'b1;
      step();
      upd_valid = 1'b0;
      chk("midsw_gp0_est0", est(0), 2);
      chk("midsw_gp0_est2", est(2), 0);

`ifdef CHAN_EST_LEAK_EN
      // Leakage with zero error: 262144 - (262144 >>> 2) = 196608.
      do_reset();
      cmd(OP_LOAD, 5'd0, 8'd4);
      set_err(0); gain = 4'd0; upd_valid = 1'b1;
      step();
      upd_valid = 1'b0;
      chk("leak_est0", est(0), 3);
      cmd(OP_READ, 5'd0, 8'd0);
      chk("leak_rd0", $signed(rd_data), 196608);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
